// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states,
// the default acceptance timeout and a helper that clamps it.
package uart_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    // Cycles the scheduler waits in WAIT_HI for the transmitter to go busy.
    localparam int TMO_CYC_DEF = 4;

    // Width of the WAIT_HI timeout counter (covers limits up to 7).
    localparam int TMO_CNT_W = 3;

    // Clamp a timeout parameter into the usable 1..7 range.
    function automatic logic [TMO_CNT_W-1:0] tmoLimit(input int cyc);
        if (cyc < 1) begin
            return TMO_CNT_W'(1);
        end else if (cyc > 7) begin
            return TMO_CNT_W'(7);
        end else begin
            return TMO_CNT_W'(cyc);
        end
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle of requester, transmitter and status signals around the scheduler.
// The slave modport is the scheduler's view; master is the environment's view.
interface uart_tx_sched_if;

    logic        REQ0_VLD;
    logic [7:0]  REQ0_DATA;
    logic        REQ0_ACK;
    logic        REQ1_VLD;
    logic [15:0] REQ1_DATA;
    logic        REQ1_ACK;
    logic [7:0]  TX_P_DATA;
    logic        TX_DATA_VALID;
    logic        TX_BUSY;
    logic        SCHED_BUSY;
    logic        ERR;
    logic        ERR_CLR;

    modport slave (
        input  REQ0_VLD, REQ0_DATA, REQ1_VLD, REQ1_DATA, TX_BUSY, ERR_CLR,
        output REQ0_ACK, REQ1_ACK, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, ERR
    );

    modport master (
        output REQ0_VLD, REQ0_DATA, REQ1_VLD, REQ1_DATA, TX_BUSY, ERR_CLR,
        input  REQ0_ACK, REQ1_ACK, TX_P_DATA, TX_DATA_VALID, SCHED_BUSY, ERR
    );

endinterface

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter. A grant is only issued while enabled, and the
// priority pointer flips to the other requester whenever a grant is taken.
module rr_arb2 (
    input  logic CLK,
    input  logic RST,
    input  logic en_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // prio_q = 0 favours requester 0, prio_q = 1 favours requester 1.
    logic prio_q;
    logic prio_d;

    // Grant decision and next priority pointer.
    always_comb begin
        gnt0_o = en_i & req0_i & (~req1_i | ~prio_q);
        gnt1_o = en_i & req1_i & (~req0_i |  prio_q);
        prio_d = prio_q;
        if (gnt0_o) begin
            prio_d = 1'b1;
        end else if (gnt1_o) begin
            prio_d = 1'b0;
        end
    end

    // Priority pointer register; reset leaves requester 0 favoured.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates two requesters frame by frame, feeds
// their bytes one at a time to a UART transmitter by watching its busy flag,
// and raises a sticky error when a byte is not picked up in time.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input logic            CLK,
    input logic            RST,
    uart_tx_sched_if.slave bus
);

    localparam logic [TMO_CNT_W-1:0] TMO_LIM = tmoLimit(TMO_CYC);

    state_e               state_q, state_d;
    logic [15:0]          buf_q, buf_d;
    logic [1:0]           byteCnt_q, byteCnt_d;
    logic [TMO_CNT_W-1:0] tmoCnt_q, tmoCnt_d;
    logic [7:0]           txData_q, txData_d;
    logic                 valid_q, valid_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 arbEn;
    logic                 gnt0;
    logic                 gnt1;

    assign arbEn = (state_q == IDLE);

    rr_arb2 uArb (
        .CLK    (CLK),
        .RST    (RST),
        .en_i   (arbEn),
        .req0_i (bus.REQ0_VLD),
        .req1_i (bus.REQ1_VLD),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        byteCnt_d = byteCnt_q;
        tmoCnt_d  = tmoCnt_q;
        txData_d  = txData_q;
        valid_d   = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        err_d     = bus.ERR_CLR ? 1'b0 : err_q;

        case (state_q)
            IDLE: begin
                tmoCnt_d = '0;
                if (gnt0) begin
                    buf_d     = {8'h00, bus.REQ0_DATA};
                    byteCnt_d = 2'd1;
                    txData_d  = bus.REQ0_DATA;
                    valid_d   = 1'b1;
                    ack0_d    = 1'b1;
                    state_d   = SEND;
                end else if (gnt1) begin
                    buf_d     = bus.REQ1_DATA;
                    byteCnt_d = 2'd2;
                    txData_d  = bus.REQ1_DATA[7:0];
                    valid_d   = 1'b1;
                    ack1_d    = 1'b1;
                    state_d   = SEND;
                end
            end

            SEND: begin
                tmoCnt_d = '0;
                state_d  = WAIT_HI;
            end

            WAIT_HI: begin
                if (bus.TX_BUSY) begin
                    tmoCnt_d = '0;
                    state_d  = WAIT_LO;
                end else if (tmoCnt_q + 1'b1 == TMO_LIM) begin
                    // Byte never accepted: flag it and abandon the frame.
                    tmoCnt_d  = '0;
                    byteCnt_d = 2'd0;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
            end

            WAIT_LO: begin
                if (!bus.TX_BUSY) begin
                    if (byteCnt_q == 2'd2) begin
                        // Swap halves so the byte just sent parks in the
                        // upper half once the high byte goes out.
                        buf_d     = {buf_q[7:0], buf_q[15:8]};
                        byteCnt_d = 2'd1;
                        txData_d  = buf_q[15:8];
                        valid_d   = 1'b1;
                        state_d   = SEND;
                    end else begin
                        byteCnt_d = 2'd0;
                        state_d   = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            byteCnt_q <= '0;
            tmoCnt_q  <= '0;
            txData_q  <= '0;
            valid_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            byteCnt_q <= byteCnt_d;
            tmoCnt_q  <= tmoCnt_d;
            txData_q  <= txData_d;
            valid_q   <= valid_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign bus.REQ0_ACK      = ack0_q;
    assign bus.REQ1_ACK      = ack1_q;
    assign bus.TX_P_DATA     = txData_q;
    assign bus.TX_DATA_VALID = valid_q;
    assign bus.SCHED_BUSY    = busy_q;
    assign bus.ERR           = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched: single-byte and two-byte frames,
// round-robin ordering, timeout error handling and mid-frame reset.
module tb_uart_tx_sched;

    logic CLK;
    logic RST;
    int   compCnt = 0;
    int   failCnt = 0;
    int   ack0Cnt = 0;
    int   ack1Cnt = 0;
    int   validCnt = 0;
    int   base0;
    int   base1;
    int   baseV;

    uart_tx_sched_if bus ();

    uart_tx_sched #(.TMO_CYC(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count handshake pulses on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (bus.REQ0_ACK)      ack0Cnt++;
        if (bus.REQ1_ACK)      ack1Cnt++;
        if (bus.TX_DATA_VALID) validCnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [15:0] d1);
        bus.REQ0_VLD  = v0;
        bus.REQ0_DATA = d0;
        bus.REQ1_VLD  = v1;
        bus.REQ1_DATA = d1;
    endtask

    task automatic applyReset();
        RST = 1'b0;
        bus.TX_BUSY = 1'b0;
        bus.ERR_CLR = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        tick();
        tick();
        RST = 1'b1;
    endtask

    // Called in the SEND cycle: walks WAIT_HI, busy for n cycles, then busy
    // falls. Returns one cycle after the fall (SEND of next byte or IDLE).
    task automatic finishByte(input logic [7:0] expData, input int n);
        tick();
        checkOutput("whValid", 16'(bus.TX_DATA_VALID), 16'h0);
        checkOutput("whData", 16'(bus.TX_P_DATA), 16'(expData));
        bus.TX_BUSY = 1'b1;
        repeat (n) begin
            tick();
            checkOutput("wlData", 16'(bus.TX_P_DATA), 16'(expData));
            checkOutput("wlSchedBusy", 16'(bus.SCHED_BUSY), 16'h1);
        end
        bus.TX_BUSY = 1'b0;
        tick();
    endtask

    initial begin
        $display("[TB] start");
        RST = 1'b0;
        applyReset();
        #0;
        checkOutput("rstAck0", 16'(bus.REQ0_ACK), 16'h0);
        checkOutput("rstData", 16'(bus.TX_P_DATA), 16'h0);
        checkOutput("rstBusy", 16'(bus.SCHED_BUSY), 16'h0);
        checkOutput("rstErr", 16'(bus.ERR), 16'h0);

        // Single byte from requester 0, busy for 10 cycles.
        base0 = ack0Cnt; baseV = validCnt;
        applyStimulus(1'b1, 8'hA5, 1'b0, 16'h0000);
        tick();
        checkOutput("t1Ack0", 16'(bus.REQ0_ACK), 16'h1);
        checkOutput("t1Ack1", 16'(bus.REQ1_ACK), 16'h0);
        checkOutput("t1Valid", 16'(bus.TX_DATA_VALID), 16'h1);
        checkOutput("t1Data", 16'(bus.TX_P_DATA), 16'h00A5);
        checkOutput("t1Busy", 16'(bus.SCHED_BUSY), 16'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        finishByte(8'hA5, 10);
        checkOutput("t1Idle", 16'(bus.SCHED_BUSY), 16'h0);
        checkOutput("t1Hold", 16'(bus.TX_P_DATA), 16'h00A5);
        tick();
        checkOutput("t1AckCnt", 16'(ack0Cnt - base0), 16'd1);
        checkOutput("t1ValidCnt", 16'(validCnt - baseV), 16'd1);

        // Two-byte frame from requester 1, low byte first.
        base1 = ack1Cnt; baseV = validCnt;
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h1234);
        tick();
        checkOutput("t2Ack1", 16'(bus.REQ1_ACK), 16'h1);
        checkOutput("t2Valid", 16'(bus.TX_DATA_VALID), 16'h1);
        checkOutput("t2Lo", 16'(bus.TX_P_DATA), 16'h0034);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        finishByte(8'h34, 3);
        checkOutput("t2Valid2", 16'(bus.TX_DATA_VALID), 16'h1);
        checkOutput("t2Hi", 16'(bus.TX_P_DATA), 16'h0012);
        checkOutput("t2NoAck", 16'(bus.REQ1_ACK), 16'h0);
        finishByte(8'h12, 3);
        checkOutput("t2Idle", 16'(bus.SCHED_BUSY), 16'h0);
        tick();
        checkOutput("t2AckCnt", 16'(ack1Cnt - base1), 16'd1);
        checkOutput("t2ValidCnt", 16'(validCnt - baseV), 16'd2);

        // Round robin: both high from reset serves req0 first, then req1.
        applyReset();
        applyStimulus(1'b1, 8'h5A, 1'b1, 16'hBEEF);
        tick();
        checkOutput("t3aAck0", 16'(bus.REQ0_ACK), 16'h1);
        checkOutput("t3aAck1", 16'(bus.REQ1_ACK), 16'h0);
        checkOutput("t3aData", 16'(bus.TX_P_DATA), 16'h005A);
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hBEEF);
        finishByte(8'h5A, 2);
        checkOutput("t3aIdle", 16'(bus.SCHED_BUSY), 16'h0);
        tick();
        checkOutput("t3bAck1", 16'(bus.REQ1_ACK), 16'h1);
        checkOutput("t3bData", 16'(bus.TX_P_DATA), 16'h00EF);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        finishByte(8'hEF, 2);
        checkOutput("t3bHi", 16'(bus.TX_P_DATA), 16'h00BE);
        finishByte(8'hBE, 2);

        // req1 was last granted, so req0 wins the next contest.
        applyStimulus(1'b1, 8'h11, 1'b1, 16'h2233);
        tick();
        checkOutput("t3cAck0", 16'(bus.REQ0_ACK), 16'h1);
        checkOutput("t3cData", 16'(bus.TX_P_DATA), 16'h0011);
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h2233);
        finishByte(8'h11, 1);
        tick();
        checkOutput("t3dAck1", 16'(bus.REQ1_ACK), 16'h1);
        checkOutput("t3dData", 16'(bus.TX_P_DATA), 16'h0033);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        finishByte(8'h33, 1);
        checkOutput("t3dHi", 16'(bus.TX_P_DATA), 16'h0022);
        finishByte(8'h22, 1);

        // After a req0 frame, a contest goes to req1.
        applyStimulus(1'b1, 8'h44, 1'b0, 16'h0000);
        tick();
        checkOutput("t3eAck0", 16'(bus.REQ0_ACK), 16'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        finishByte(8'h44, 1);
        applyStimulus(1'b1, 8'h55, 1'b1, 16'h6677);
        tick();
        checkOutput("t3fAck1", 16'(bus.REQ1_ACK), 16'h1);
        checkOutput("t3fAck0", 16'(bus.REQ0_ACK), 16'h0);
        checkOutput("t3fData", 16'(bus.TX_P_DATA), 16'h0077);
        applyStimulus(1'b1, 8'h55, 1'b0, 16'h0000);
        finishByte(8'h77, 1);
        checkOutput("t3fHi", 16'(bus.TX_P_DATA), 16'h0066);
        finishByte(8'h66, 1);
        tick();
        checkOutput("t3gAck0", 16'(bus.REQ0_ACK), 16'h1);
        checkOutput("t3gData", 16'(bus.TX_P_DATA), 16'h0055);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        finishByte(8'h55, 1);

        // Timeout: busy never rises, ERR after 4 cycles in WAIT_HI.
        baseV = validCnt;
        applyStimulus(1'b0, 8'h00, 1'b1, 16'hCAFE);
        tick();
        checkOutput("t4Data", 16'(bus.TX_P_DATA), 16'h00FE);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4ErrLow", 16'(bus.ERR), 16'h0);
        end
        tick();
        checkOutput("t4ErrSet", 16'(bus.ERR), 16'h1);
        checkOutput("t4Idle", 16'(bus.SCHED_BUSY), 16'h0);
        tick();
        tick();
        checkOutput("t4Sticky", 16'(bus.ERR), 16'h1);
        checkOutput("t4NoHi", 16'(validCnt - baseV), 16'd1);
        checkOutput("t4DataHold", 16'(bus.TX_P_DATA), 16'h00FE);
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        checkOutput("t4Clr", 16'(bus.ERR), 16'h0);

        // Timeout and ERR_CLR on the same edge: set wins.
        applyStimulus(1'b1, 8'h77, 1'b0, 16'h0000);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        tick();
        tick();
        tick();
        tick();
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;
        checkOutput("t6SetWins", 16'(bus.ERR), 16'h1);
        bus.ERR_CLR = 1'b1;
        tick();
        bus.ERR_CLR = 1'b0;

        // Reset during WAIT_LO of a req1 frame.
        base1 = ack1Cnt; baseV = validCnt;
        applyStimulus(1'b0, 8'h00, 1'b1, 16'h5566);
        tick();
        checkOutput("t5Data", 16'(bus.TX_P_DATA), 16'h0066);
        applyStimulus(1'b0, 8'h00, 1'b0, 16'h0000);
        tick();
        bus.TX_BUSY = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        checkOutput("t5RstData", 16'(bus.TX_P_DATA), 16'h0000);
        checkOutput("t5RstBusy", 16'(bus.SCHED_BUSY), 16'h0);
        checkOutput("t5RstValid", 16'(bus.TX_DATA_VALID), 16'h0);
        checkOutput("t5RstAck", 16'(bus.REQ1_ACK), 16'h0);
        tick();
        RST = 1'b1;
        bus.TX_BUSY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5NoSend", 16'(bus.SCHED_BUSY), 16'h0);
        end
        checkOutput("t5ValidCnt", 16'(validCnt - baseV), 16'd1);
        checkOutput("t5AckCnt", 16'(ack1Cnt - base1), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule
